// File: rtl/dec_signal_monitor.sv
// Checker/encoder for the upstream one-hot decoder vector: registers the sample,
// encodes it to a phase index and tracks advance/hold sequencing with lock and error reporting.
module dec_signal_monitor #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic [WIDTH-1:0]         dec_signal,
    output logic [$clog2(WIDTH)-1:0] phase,
    output logic                     phase_valid,
    output logic                     locked,
    output logic [CNT_W-1:0]         wrap_count,
    output logic                     err,
    output logic [CNT_W-1:0]         err_count
);

    localparam int IDX_W = $clog2(WIDTH);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SYNC  = 2'd1;
    localparam logic [1:0] ST_TRACK = 2'd2;
    localparam logic [1:0] ST_ERROR = 2'd3;

    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [WIDTH-1:0] dec_q, dec_d;
    logic [IDX_W-1:0] phase_q, phase_d;
    logic             pv_q, pv_d;
    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] exp_q, exp_d;
    logic [CNT_W-1:0] wrap_q, wrap_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] errc_q, errc_d;

    logic             ok;
    logic [IDX_W-1:0] idx;

    // Mask of vector positions whose index has bit b set; OR-reducing against it
    // yields index bit b whenever the vector is one-hot.
    function automatic logic [WIDTH-1:0] sel_mask(input int b);
        logic [WIDTH-1:0] m;
        for (int p = 0; p < WIDTH; p++) begin
            m[p] = p[b];
        end
        return m;
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < IDX_W; gi++) begin : g_idx
            assign idx[gi] = |(dec_q & sel_mask(gi));
        end
    endgenerate

    assign ok = (dec_q != '0) && ((dec_q & (dec_q - WIDTH'(1))) == '0);

    always_comb begin
        dec_d   = dec_q;
        phase_d = phase_q;
        pv_d    = pv_q;
        state_d = state_q;
        exp_d   = exp_q;
        wrap_d  = wrap_q;
        err_d   = err_q;
        errc_d  = errc_q;

        // ERROR lasts exactly one cycle even while the block is frozen.
        if (state_q == ST_ERROR) begin
            state_d = ST_SYNC;
        end

        if (en) begin
            dec_d = dec_signal;
            pv_d  = ok;
            if (ok) begin
                phase_d = idx;
            end
            case (state_q)
                ST_IDLE: state_d = ST_SYNC;
                ST_SYNC: begin
                    if (ok && idx == '0) begin
                        state_d = ST_TRACK;
                        exp_d   = IDX_ONE;
                    end
                end
                ST_TRACK: begin
                    if (ok && idx == exp_q) begin
                        exp_d = exp_q + IDX_ONE;
                        if (idx == '0) begin
                            wrap_d = wrap_q + CNT_ONE;
                        end
                    end else if (ok && idx == (exp_q - IDX_ONE)) begin
                        state_d = ST_TRACK;
                    end else begin
                        state_d = ST_ERROR;
                        err_d   = 1'b1;
                        if (errc_q != CNT_MAX) begin
                            errc_d = errc_q + CNT_ONE;
                        end
                    end
                end
                default: state_d = ST_SYNC;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dec_q   <= '0;
            phase_q <= '0;
            pv_q    <= 1'b0;
            state_q <= ST_IDLE;
            exp_q   <= '0;
            wrap_q  <= '0;
            err_q   <= 1'b0;
            errc_q  <= '0;
        end else begin
            dec_q   <= dec_d;
            phase_q <= phase_d;
            pv_q    <= pv_d;
            state_q <= state_d;
            exp_q   <= exp_d;
            wrap_q  <= wrap_d;
            err_q   <= err_d;
            errc_q  <= errc_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = pv_q;
    assign locked      = (state_q == ST_TRACK);
    assign wrap_count  = wrap_q;
    assign err         = err_q;
    assign err_count   = errc_q;

endmodule

// File: tb/tb_dec_signal_monitor.sv
// Randomized and directed bench for dec_signal_monitor against a behavioural
// model of the sampling, lock and error rules.
module tb_dec_signal_monitor;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en = 1'b0;
    logic [15:0] dec_signal = '0;
    logic [3:0]  phase;
    logic        phase_valid;
    logic        locked;
    logic [7:0]  wrap_count;
    logic        err;
    logic [7:0]  err_count;

    int n_total = 0;
    int n_pass  = 0;

    dec_signal_monitor #(.WIDTH(16), .CNT_W(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .en          (en),
        .dec_signal  (dec_signal),
        .phase       (phase),
        .phase_valid (phase_valid),
        .locked      (locked),
        .wrap_count  (wrap_count),
        .err         (err),
        .err_count   (err_count)
    );

    always #5 clk = ~clk;

    // Behavioural model: mode 0=waiting for first enable, 1=searching for index 0,
    // 2=tracking, 3=one-cycle error recovery.
    logic [15:0] m_q = '0;
    int          m_phase = 0;
    bit          m_pv = 0;
    int          m_mode = 0;
    int          m_exp = 0;
    int          m_wrap = 0;
    bit          m_err = 0;
    int          m_errc = 0;

    function automatic int first_set(input logic [15:0] v);
        for (int p = 0; p < 16; p++) if (v[p]) return p;
        return 0;
    endfunction

    function automatic logic [22:0] model_vec();
        return {4'(m_phase), m_pv, (m_mode == 2), 8'(m_wrap), m_err, 8'(m_errc)};
    endfunction

    task automatic step(input logic r, input logic e, input logic [15:0] v);
        bit good;
        int id;
        reset = r; en = e; dec_signal = v;
        @(posedge clk);
        if (r) begin
            m_q = '0; m_phase = 0; m_pv = 0; m_mode = 0;
            m_exp = 0; m_wrap = 0; m_err = 0; m_errc = 0;
        end else if (e) begin
            good = ($countones(m_q) == 1);
            id   = first_set(m_q);
            m_pv = good;
            if (good) m_phase = id;
            case (m_mode)
                0: m_mode = 1;
                1: if (good && id == 0) begin m_mode = 2; m_exp = 1; end
                2: begin
                    if (good && id == m_exp) begin
                        m_exp = (m_exp + 1) % 16;
                        if (id == 0) m_wrap = (m_wrap + 1) % 256;
                    end else if (!(good && id == (m_exp + 15) % 16)) begin
                        m_mode = 3; m_err = 1;
                        m_errc = (m_errc < 255) ? m_errc + 1 : 255;
                    end
                end
                default: m_mode = 1;
            endcase
            m_q = v;
        end else if (m_mode == 3) begin
            m_mode = 1;
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 1, 16'h8000);
        step(1, 1, 16'h8000);
        n_total++;
        if ({phase, phase_valid, locked, wrap_count, err, err_count} !== 23'd0)
            $display("FAIL reset_outputs: got %h want 0",
                     {phase, phase_valid, locked, wrap_count, err, err_count});
        else n_pass++;
    endtask

    task automatic test_rotation();
        logic [15:0] seq [18];
        for (int i = 0; i < 16; i++) seq[i] = 16'(1) << i;
        seq[16] = 16'h0001;
        seq[17] = 16'h0002;
        for (int i = 0; i < 18; i++) begin
            step(0, 1, seq[i]);
            if (i >= 1) begin
                n_total++;
                if (locked !== 1'b1 || phase !== 4'(first_set(seq[i-1])))
                    $display("FAIL rotation_step%0d: locked=%b phase=%0d want locked=1 phase=%0d",
                             i, locked, phase, first_set(seq[i-1]));
                else n_pass++;
                n_total++;
                if (wrap_count !== ((i == 17) ? 8'd1 : 8'd0) || err !== 1'b0)
                    $display("FAIL rotation_wrap%0d: wrap=%0d err=%b want wrap=%0d err=0",
                             i, wrap_count, err, (i == 17));
                else n_pass++;
            end
        end
    endtask

    task automatic test_hold();
        step(0, 1, 16'h0004);
        for (int i = 0; i < 3; i++) step(0, 1, 16'h0008);
        n_total++;
        if (locked !== 1'b1 || err !== 1'b0 || phase !== 4'd3)
            $display("FAIL hold: locked=%b err=%b phase=%0d want 1 0 3", locked, err, phase);
        else n_pass++;
    endtask

    task automatic test_skip();
        step(0, 1, 16'h0020);
        n_total++;
        if (locked !== 1'b1 || phase !== 4'd3)
            $display("FAIL skip_hold_last: locked=%b phase=%0d want 1 3", locked, phase);
        else n_pass++;
        step(0, 1, 16'h0040);
        n_total++;
        if (err !== 1'b1 || err_count !== 8'd1 || locked !== 1'b0)
            $display("FAIL skip_detect: err=%b cnt=%0d locked=%b want 1 1 0", err, err_count, locked);
        else n_pass++;
        step(0, 1, 16'h0080);
        step(0, 1, 16'h0001);
        n_total++;
        if (locked !== 1'b0)
            $display("FAIL skip_unlocked: locked=%b want 0", locked);
        else n_pass++;
        step(0, 1, 16'h0002);
        n_total++;
        if (locked !== 1'b1 || {phase, phase_valid, locked, wrap_count, err, err_count} !== model_vec())
            $display("FAIL skip_relock: got %h want %h locked=%b",
                     {phase, phase_valid, locked, wrap_count, err, err_count}, model_vec(), locked);
        else n_pass++;
    endtask

    task automatic test_invalid();
        step(0, 1, 16'h0000);
        step(0, 1, 16'h0004);
        n_total++;
        if (phase_valid !== 1'b0 || err_count !== 8'd2 || phase !== 4'd1 || locked !== 1'b0)
            $display("FAIL invalid_zero: pv=%b cnt=%0d phase=%0d locked=%b want 0 2 1 0",
                     phase_valid, err_count, phase, locked);
        else n_pass++;
        step(0, 1, 16'h0001);
        step(0, 1, 16'h0002);
        step(0, 1, 16'h0003);
        step(0, 1, 16'h0008);
        n_total++;
        if (phase_valid !== 1'b0 || err_count !== 8'd3 || phase !== 4'd1)
            $display("FAIL invalid_multi: pv=%b cnt=%0d phase=%0d want 0 3 1",
                     phase_valid, err_count, phase);
        else n_pass++;
    endtask

    task automatic test_saturation();
        logic [15:0] pat [3];
        pat[0] = 16'h0001; pat[1] = 16'h0000; pat[2] = 16'h0000;
        for (int i = 0; i < 1000; i++) step(0, 1, pat[i % 3]);
        n_total++;
        if (err_count !== 8'd255 || m_errc != 255)
            $display("FAIL sat_reach: cnt=%0d model=%0d want 255", err_count, m_errc);
        else n_pass++;
        for (int i = 0; i < 30; i++) step(0, 1, pat[i % 3]);
        n_total++;
        if (err_count !== 8'd255 || err !== 1'b1)
            $display("FAIL sat_stay: cnt=%0d err=%b want 255 1", err_count, err);
        else n_pass++;
    endtask

    task automatic test_enable_freeze();
        logic [22:0] snap;
        step(0, 1, 16'h0001);
        step(0, 1, 16'h0002);
        step(0, 1, 16'h0004);
        snap = model_vec();
        for (int i = 0; i < 10; i++) begin
            step(0, 0, 16'($urandom));
            n_total++;
            if ({phase, phase_valid, locked, wrap_count, err, err_count} !== snap)
                $display("FAIL freeze%0d: got %h want %h", i,
                         {phase, phase_valid, locked, wrap_count, err, err_count}, snap);
            else n_pass++;
        end
    endtask

    task automatic test_reset_in_error();
        step(0, 1, 16'h0001);
        step(0, 1, 16'h0002);
        step(0, 1, 16'h0010);
        step(0, 1, 16'h0010);
        step(1, 1, 16'h0001);
        n_total++;
        if ({phase, phase_valid, locked, wrap_count, err, err_count} !== 23'd0)
            $display("FAIL reset_priority: got %h want 0",
                     {phase, phase_valid, locked, wrap_count, err, err_count});
        else n_pass++;
    endtask

    task automatic test_random();
        int k = 0;
        int r;
        logic [15:0] v;
        logic e, rs;
        for (int i = 0; i < 1500; i++) begin
            r = $urandom_range(0, 99);
            e = 1'b1; rs = 1'b0;
            if (r < 70)      k = (k + 1) % 16;
            else if (r < 82) k = k;
            else if (r < 88) k = $urandom_range(0, 15);
            else if (r < 96) e = 1'b0;
            else if (r < 99) k = (k + 15) % 16;
            else             rs = 1'b1;
            v = 16'(1) << k;
            if ($urandom_range(0, 49) == 0) v = 16'($urandom);
            step(rs, e, v);
            n_total++;
            if ({phase, phase_valid, locked, wrap_count, err, err_count} !== model_vec())
                $display("FAIL random%0d: got %h want %h", i,
                         {phase, phase_valid, locked, wrap_count, err, err_count}, model_vec());
            else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_rotation();
        test_hold();
        test_skip();
        test_invalid();
        test_saturation();
        test_enable_freeze();
        test_reset_in_error();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
